// File: rtl/gpr_wb.sv
// gpr_wb: writeback arbiter (LSU over ALU), register busy scoreboard and operand bypass.
module gpr_wb #(
  parameter int XLEN = 32,
  parameter int NUM = 32,
  localparam int AW = $clog2(NUM)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic [XLEN-1:0] gpr_r1,
  input  logic [XLEN-1:0] gpr_r2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            stall,
  output logic [AW-1:0]   addr_w,
  output logic [XLEN-1:0] data_w,
  output logic [AW:0]     pending_cnt
);
  logic [NUM-1:0] busy, set_v, clr_v;
  logic acc, inc, dec;
  logic [AW-1:0] acc_rd;
  logic [XLEN-1:0] acc_data;
  assign lsu_ready = 1'b1;
  assign alu_ready = !lsu_valid;
  // an ALU accept needs !lsu_valid, so any valid source yields exactly one accept
  assign acc = lsu_valid || alu_valid;
  assign acc_rd = lsu_valid ? lsu_rd : alu_rd;
  assign acc_data = lsu_valid ? lsu_data : alu_data;
  assign set_v = (issue_valid && issue_rd != '0) ? NUM'(1) << issue_rd : '0;
  assign clr_v = (acc && acc_rd != '0) ? NUM'(1) << acc_rd : '0;
  assign inc = |(set_v & ~busy);
  assign dec = |(clr_v & busy & ~set_v);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
      pending_cnt <= '0;
      addr_w <= '0;
      data_w <= '0;
    end else begin
      busy <= (busy & ~clr_v) | set_v;
      pending_cnt <= pending_cnt + (AW+1)'(inc) - (AW+1)'(dec);
      addr_w <= acc ? acc_rd : '0;
      if (acc) data_w <= acc_data;
    end
  end
  assign stall = (rs1_addr != '0 && busy[rs1_addr]) || (rs2_addr != '0 && busy[rs2_addr]);
  assign rs1_data = (addr_w != '0 && addr_w == rs1_addr) ? data_w : gpr_r1;
  assign rs2_data = (addr_w != '0 && addr_w == rs2_addr) ? data_w : gpr_r2;
endmodule
